// File: rtl/filter_conv_ctrl.sv
// Conversion sequencer: resets the decimation filter, discards settling words, averages 2^cfg_avg words.
// Optional watchdog built when CONV_TIMEOUT_EN is defined.
module filter_conv_ctrl #(
    parameter int DISCARD = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  cfg_avg,
    input  logic [11:0] filt_data,
    input  logic        filt_new_data,
    output logic        filt_rst_n,
    output logic        mod_en,
    output logic        busy,
    output logic [11:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        err
);
    // state  | meaning
    // IDLE   | waiting for start, filter held in reset
    // FRST   | two-cycle filter reset before the modulator runs
    // SETTLE | discarding DISCARD filter words
    // ACC    | accumulating 2^cfg_avg filter words
    // DONE   | result valid, waiting for result_ready
    typedef enum logic [2:0] {IDLE, FRST, SETTLE, ACC, DONE} state_t;

    localparam logic [2:0] DISC_LAST = 3'(DISCARD - 1);

    state_t      state;
    logic [1:0]  avg_q;
    logic [14:0] acc;
    logic [14:0] acc_sum;
    logic [11:0] avg_word;
    logic        frst_cnt;
    logic [2:0]  disc_cnt;
    logic [2:0]  word_cnt;
    logic [2:0]  word_last;

    assign acc_sum   = acc + {3'b000, filt_data};
    assign word_last = 3'((4'd1 << avg_q) - 4'd1);

    always_comb begin
        case (avg_q)
            2'd0:    avg_word = acc_sum[11:0];
            2'd1:    avg_word = acc_sum[12:1];
            2'd2:    avg_word = acc_sum[13:2];
            default: avg_word = acc_sum[14:3];
        endcase
    end

`ifdef CONV_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt;
    logic        wd_fire;
    logic        err_q;

    // A strobe on the terminal cycle wins over the timeout.
    assign wd_fire = (state == SETTLE || state == ACC) && !filt_new_data && (wd_cnt == WD_LAST);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((state == SETTLE || state == ACC) && !filt_new_data && !wd_fire) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    // Without the watchdog err can never set; TIMEOUT only matters when it is built.
    assign err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            filt_rst_n   <= 1'b0;
            mod_en       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            avg_q        <= '0;
            acc          <= '0;
            frst_cnt     <= 1'b0;
            disc_cnt     <= '0;
            word_cnt     <= '0;
`ifdef CONV_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FRST;
                        busy     <= 1'b1;
                        avg_q    <= cfg_avg;
                        acc      <= '0;
                        frst_cnt <= 1'b0;
                        disc_cnt <= '0;
                        word_cnt <= '0;
`ifdef CONV_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                FRST: begin
                    frst_cnt <= 1'b1;
                    if (frst_cnt) begin
                        frst_cnt   <= 1'b0;
                        filt_rst_n <= 1'b1;
                        mod_en     <= 1'b1;
                        state      <= (DISCARD == 0) ? ACC : SETTLE;
                    end
                end
                SETTLE, ACC: begin
                    if (filt_new_data) begin
                        if (state == SETTLE) begin
                            disc_cnt <= disc_cnt + 3'd1;
                            if (disc_cnt == DISC_LAST) begin
                                state <= ACC;
                            end
                        end else begin
                            acc      <= acc_sum;
                            word_cnt <= word_cnt + 3'd1;
                            if (word_cnt == word_last) begin
                                state        <= DONE;
                                result       <= avg_word;
                                result_valid <= 1'b1;
                                filt_rst_n   <= 1'b0;
                                mod_en       <= 1'b0;
                            end
                        end
                    end
`ifdef CONV_TIMEOUT_EN
                    else if (wd_fire) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        filt_rst_n <= 1'b0;
                        mod_en     <= 1'b0;
                        err_q      <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/filter_conv_ctrl.md
FILTER_CONV_CTRL -- requirements
Module: filter_conv_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DISCARD, 1, number of filter output words discarded after filter reset (range 0-7).
- TIMEOUT, 1024, cycles allowed between filter output words before abort (range 2-65535).

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, conversion request; sampled only in IDLE.
- cfg_avg, in, 2, averaging exponent; N = 2^cfg_avg words (1, 2, 4 or 8); sampled with start.
- filt_data, in, 12, filter output word.
- filt_new_data, in, 1, one-cycle strobe marking filt_data valid.
- filt_rst_n, out, 1, active-low reset driven to the digital_filter.
- mod_en, out, 1, modulator bitstream enable.
- busy, out, 1, high in any state other than IDLE.
- result, out, 12, averaged conversion result.
- result_valid, out, 1, result available.
- result_ready, in, 1, consumer accepts result.
- err, out, 1, sticky timeout flag.

REQ-003 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, FRST, SETTLE, ACC and DONE.

REQ-005 IDLE to FRST SHALL occur on the first clk edge with start=1. On that edge the block latches cfg_avg and clears err, the accumulator and all counters.

REQ-006 FRST:
- filt_rst_n=0 and mod_en=0 for exactly 2 cycles, then go to SETTLE.
- If DISCARD=0, go directly to ACC instead.

REQ-007 SETTLE and ACC:
- filt_rst_n=1 and mod_en=1.
- filt_new_data outside SETTLE and ACC SHALL be ignored.

REQ-008 SETTLE:
- Each filt_new_data strobe increments the discard counter; filt_data is ignored.
- When the counter reaches DISCARD, go to ACC on the same edge.

REQ-009 ACC:
- Each filt_new_data strobe adds zero-extended filt_data into a 15-bit accumulator and increments the word counter.
- Word N SHALL cause the transition to DONE on the same edge.
- Overflow is impossible: 8 x 4095 < 2^15.

REQ-010 Result: on entry to DONE, result SHALL register accumulator >> latched cfg_avg (truncating), so result_valid rises 1 cycle after the Nth strobe.

REQ-011 DONE:
- filt_rst_n=0, mod_en=0, result_valid=1.
- result SHALL stay stable until result_valid and result_ready are both high at a clk edge; then go to IDLE and deassert result_valid on that edge.

REQ-012 start SHALL be ignored outside IDLE, including in DONE while result_valid=1.

REQ-013 result SHALL hold its last value in IDLE. result_valid SHALL be 0 in all states except DONE.

REQ-014 busy SHALL be a registered decode of state != IDLE.

REQ-015 Timeout watchdog (only when CONV_TIMEOUT_EN is defined):
- A 16-bit counter counts cycles in SETTLE and ACC and clears on each filt_new_data strobe.
- When it reaches TIMEOUT: set err=1, go to IDLE, drive filt_rst_n=0 and mod_en=0; no result is produced.

REQ-016 A timeout and a filt_new_data strobe on the same edge: the strobe SHALL win, so no timeout occurs.

REQ-017 In IDLE: filt_rst_n=0, mod_en=0.

Reset
REQ-018 rst_n=0 at any time, including mid-conversion, SHALL immediately force:
- state=IDLE, busy=0
- filt_rst_n=0, mod_en=0
- result=0, result_valid=0, err=0
- accumulator=0 and all counters=0

REQ-019 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Configuration
REQ-020 Macro CONV_TIMEOUT_EN:
- Defined: REQ-015 and REQ-016 apply.
- Undefined: no watchdog counter is built, err is tied to 0, and SETTLE and ACC wait indefinitely.

Verification
REQ-021 The bench SHALL use a filter model producing a filt_new_data strobe every 512 cycles after filt_rst_n rises. Required scenarios:
- DISCARD=1, cfg_avg=0, words 100 then 2000 -> result=2000, result_valid 1 cycle after the 2nd strobe, filt_rst_n low 2 cycles after start.
- cfg_avg=2, words after discard 10, 11, 12, 13 -> result=11; result_ready held low 50 cycles -> result and result_valid stable for all 50 cycles.
- cfg_avg=3, eight words of 4095 -> result=4095, no wrap.
- rst_n pulsed low in ACC after 2 words -> all outputs at reset values within the same cycle; next start gives a clean full conversion.
- CONV_TIMEOUT_EN, TIMEOUT=1024, model strobes stopped in ACC -> err=1 and IDLE exactly 1024 cycles after the last strobe; next start clears err.
- start pulsed in DONE and in ACC -> ignored; conversion count unchanged.
